// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline hazard and multi-cycle scheduling controller for the 5-stage MIPS
// core. Sits beside the forwarding logic in ID and does the following:
//   - Detects load-use hazards that forwarding cannot resolve.
//   - Sequences the shared multiply/divide unit: issue, busy tracking and the
//     HI/LO read interlock.
//   - Drives the pipeline write enables, the ID/EX bubble and the IF/ID flush.
//   - Keeps a saturating count of stalled cycles.
//
// Parameters
//   MUL_LAT  multiply latency in cycles (>=1)
//   DIV_LAT  divide latency in cycles (>=1)
//   CNT_W    latency counter width, must hold max(MUL_LAT, DIV_LAT)
//   STAT_W   stall statistics counter width
//
// Ports
//   CLK, Reset_L          clock (rising edge) / async active-low reset
//   ID_Rs, ID_Rt          source registers of the instruction in ID
//   ID_UsesRs, ID_UsesRt  the ID instruction really reads Rs / Rt
//   EX_Rw, EX_MemRead     destination / is-load of the instruction in EX
//   ID_MulDiv, ID_IsDiv   ID holds MULT(U)/DIV(U); ID_IsDiv selects divide
//   ID_ReadsHiLo          ID holds MFHI/MFLO
//   ID_BranchTaken        branch/jump in ID resolved taken
//   ClrStats              synchronous clear of StallCount
//   PCWrite, IFID_Write   pipeline front-end write enables
//   IDEX_Bubble           zero control fields entering ID/EX
//   IFID_Flush            squash the instruction in IF/ID
//   MD_Start, MD_IsDiv    one-cycle issue pulse and operation select
//   MD_Busy, MD_Done      unit occupied / final cycle of the operation
//   StallCount            saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6,
   parameter int STAT_W  = 16
) (
   input  logic              CLK,
   input  logic              Reset_L,
   input  logic [4:0]        ID_Rs,
   input  logic [4:0]        ID_Rt,
   input  logic              ID_UsesRs,
   input  logic              ID_UsesRt,
   input  logic [4:0]        EX_Rw,
   input  logic              EX_MemRead,
   input  logic              ID_MulDiv,
   input  logic              ID_IsDiv,
   input  logic              ID_ReadsHiLo,
   input  logic              ID_BranchTaken,
   input  logic              ClrStats,
   output logic              PCWrite,
   output logic              IFID_Write,
   output logic              IDEX_Bubble,
   output logic              IFID_Flush,
   output logic              MD_Start,
   output logic              MD_IsDiv,
   output logic              MD_Busy,
   output logic              MD_Done,
   output logic [STAT_W-1:0] StallCount
);

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } mdState_t;

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   mdState_t          stateReg, stateNext;
   logic [CNT_W-1:0]  cntReg, cntNext;
   logic              doneReg, doneNext;
   logic [STAT_W-1:0] statReg;

   logic loadUse;
   logic mdStall;
   logic stall;
   logic mdStart;

   // Hazard detection. r0 is never a real dependency.
   assign loadUse = EX_MemRead && (EX_Rw != 5'd0) &&
                    ((ID_UsesRs && (EX_Rw == ID_Rs)) ||
                     (ID_UsesRt && (EX_Rw == ID_Rt)));

   // A new mul/div may issue in the Done cycle (the unit frees up at the end
   // of it), but an MFHI/MFLO must wait until HI/LO have been written.
   assign mdStall = (ID_ReadsHiLo && MD_Busy) ||
                    (ID_MulDiv && MD_Busy && !doneReg);

   // During reset all control outputs take their pass-through values.
   assign stall   = (loadUse || mdStall) && Reset_L;
   assign mdStart = ID_MulDiv && !stall && Reset_L;

   assign PCWrite     = !stall;
   assign IFID_Write  = !stall;
   assign IDEX_Bubble = stall;
   assign IFID_Flush  = ID_BranchTaken && !stall && Reset_L;
   assign MD_Start    = mdStart;
   assign MD_IsDiv    = ID_IsDiv && mdStart;

   // Busy/Done come straight from flops so the mul/div unit sees clean levels.
   assign MD_Busy    = (stateReg == MD_RUN);
   assign MD_Done    = doneReg;
   assign StallCount = statReg;

   // Mul/div sequencer: next-state logic
   always_comb begin
      stateNext = stateReg;
      cntNext   = cntReg;
      if (mdStart) begin
         stateNext = MD_RUN;
         cntNext   = ID_IsDiv ? DIV_CNT : MUL_CNT;
      end else if (stateReg == MD_RUN) begin
         if (cntReg == CNT_ONE) begin
            stateNext = MD_IDLE;
            cntNext   = '0;
         end else begin
            cntNext = cntReg - CNT_ONE;
         end
      end
      // Pre-decode Done one cycle early so it is a registered signal.
      doneNext = (stateNext == MD_RUN) && (cntNext == CNT_ONE);
   end

   // Mul/div sequencer: state register
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         stateReg <= MD_IDLE;
         cntReg   <= '0;
         doneReg  <= 1'b0;
      end else begin
         stateReg <= stateNext;
         cntReg   <= cntNext;
         doneReg  <= doneNext;
      end
   end

   // Stall statistics: clear wins, otherwise count stalled cycles and stick at
   // all ones.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         statReg <= '0;
      end else if (ClrStats) begin
         statReg <= '0;
      end else if (stall && (statReg != {STAT_W{1'b1}})) begin
         statReg <= statReg + STAT_W'(1);
      end
   end

endmodule
